fork_sched: RTL and testbench
=============================

# fork_sched

Fork scheduler for the multi-core threadbrain array. It owns the busy/idle state of all NCORES cores and boots core 0 after reset. It accepts fork requests from running cores, arbitrating round-robin when several arrive together, and allocates the lowest-numbered idle core to each granted request. It drives each core's 33-bit fork context bus: start flag, data pointer and start PC.

## Interface
- NCORES, default 4, number of cores, legal range 2..16.
- BOOT_PTR, default 16'd128, data pointer given to core 0 at boot.
- BOOT_PC, default 16'h0000, start PC given to core 0 at boot.
- clk  in  1  system clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fork_req  in  NCORES  per-core fork request; level, held until acked.
- fork_ptr  in  NCORES*16  child data pointer, slice [i*16 +: 16] for core i.
- fork_pc  in  NCORES*16  child start PC, slice [i*16 +: 16] for core i.
- halt  in  NCORES  per-core one-cycle pulse: core finished its thread.
- fork_ack  out  NCORES  one-cycle grant pulse to the requesting core.
- fork_cxt  out  NCORES*33  per-core context, slice [i*33 +: 33]:
  - bit 32: start.
  - [31:16]: ptr.
  - [15:0]: pc.
- busy  out  NCORES  core is allocated/running.
- all_done  out  1  program finished (FSM in DONE).

## Operation
- FSM states and transitions:
  - BOOT: entered on reset; lasts one cycle, then RUN.
  - RUN → DONE: when busy == 0 and no start is pending.
  - DONE: sticky until rst.
- Boot sequence:
  - In BOOT, the registered outputs load core 0's start.
  - Core 0 sees fork_cxt start = 1, ptr = BOOT_PTR, pc = BOOT_PC for one cycle.
  - busy[0] becomes 1.
- Eligibility: core i is eligible in RUN when fork_req[i] & busy[i] & !halt[i] & !fork_ack[i].
  - The ack mask stops a request still held during its ack cycle from being granted twice.
- Grant selection:
  - Round-robin pointer rr (log2 NCORES bits); search starts at rr, ascending with wrap.
  - At most one grant per cycle.
- Child selection:
  - Lowest index with busy == 0 and no start pending.
  - A core freed by halt in cycle N is not allocatable until cycle N+1.
- On a grant to requester r for child c (registered):
  - fork_ack[r] = 1.
  - fork_cxt[c] = {1, fork_ptr[r], fork_pc[r]}.
  - busy[c] set.
  - rr ← r+1 mod NCORES.
- No idle core: no grant, rr unchanged, requests stay pending (requester keeps stalling).
- halt[i] on a busy core clears busy[i]. halt on an idle core is ignored.
- Requests from idle cores are ignored.
- DONE: all requests ignored, all outputs held at reset values except all_done = 1.

## Timing
- Reset values:
  - fork_ack = 0, fork_cxt = 0, busy = 0, all_done = 0.
  - rr = 0, state = BOOT.
- All outputs are registered.
- Fork latency: request sampled at edge N; ack and start visible during cycle N+1 (one cycle).
- Start and ack are exactly one cycle wide. The fork_cxt ptr/pc fields are 0 whenever start = 0.
- Back-to-back forks: one grant per cycle sustained while idle cores remain.
- Simultaneous halt and fork on the same core in one cycle: halt wins, the request is dropped, no ack.
- Reset mid-operation:
  - Pending starts and acks are aborted immediately (asynchronous).
  - Boot repeats after rst deasserts.
- all_done rises one cycle after the last busy bit clears.

## Configuration
- FORK_SCHED_STATS_EN defined adds two output ports:
  - fork_count (16-bit): total grants including boot.
  - starve_count (16-bit): cycles with at least one eligible request and no grant.
  - Both saturate at 16'hFFFF and reset to 0.
- FORK_SCHED_STATS_EN undefined: these ports and their counters do not exist; all other behaviour is identical.

## Test plan
- Reset → BOOT: release rst, NCORES = 4 → cycle 1 fork_cxt[0] = {1, 16'd128, 16'h0000}, busy = 4'b0001, then start = 0.
- Single fork: core 0 requests ptr = 16'h0090, pc = 16'h0010 → next cycle fork_ack[0] = 1, fork_cxt[1] = {1, 16'h0090, 16'h0010}, busy = 4'b0011.
- Round-robin: cores 0..3 busy except core 3 freed by halt.
  - Cores 0 and 1 request together, rr = 1.
  - First grant goes to core 1.
  - Core 0 waits with no ack while no idle core remains.
- Saturation: all 4 cores busy, core 2 requests for 10 cycles → no ack, busy unchanged; halt[3] → core 2 granted child 3 two cycles after the halt pulse.
- Done and reset: halt all busy cores → all_done = 1 one cycle later; fork_req ignored while all_done = 1; assert rst mid-grant → all outputs 0 immediately, boot repeats after release.
- Stats (with FORK_SCHED_STATS_EN): boot plus 3 forks → fork_count = 4; 5 starved cycles → starve_count = 5.

Source files
------------

// File: rtl/fork_sched.sv
// Fork scheduler: boots core 0, grants fork requests round-robin and starts the lowest idle core.
// Optional FORK_SCHED_STATS_EN adds saturating fork_count / starve_count outputs.
module fork_sched #(
    parameter int          NCORES   = 4,
    parameter logic [15:0] BOOT_PTR = 16'd128,
    parameter logic [15:0] BOOT_PC  = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCORES-1:0]      fork_req,
    input  logic [NCORES*16-1:0]   fork_ptr,
    input  logic [NCORES*16-1:0]   fork_pc,
    input  logic [NCORES-1:0]      halt,
    output logic [NCORES-1:0]      fork_ack,
    output logic [NCORES*33-1:0]   fork_cxt,
    output logic [NCORES-1:0]      busy,
    output logic                   all_done
`ifdef FORK_SCHED_STATS_EN
    ,
    output logic [15:0]            fork_count,
    output logic [15:0]            starve_count
`endif
);

    localparam int          RRW  = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int unsigned NC_U = NCORES;

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_DONE} state_t;

    state_t                 r_state;
    logic [NCORES-1:0]      r_ack;
    logic [NCORES*33-1:0]   r_cxt;
    logic [NCORES-1:0]      r_busy;
    logic                   r_done;
    logic [RRW-1:0]         r_rr;
    logic [15:0]            r_fork_cnt;
    logic [15:0]            r_starve_cnt;

    logic [NCORES-1:0]      w_elig;
    logic [NCORES-1:0]      w_start;
    logic [NCORES-1:0]      w_busy_nxt;
    logic [NCORES-1:0]      w_ack_nxt;
    logic [NCORES*33-1:0]   w_cxt_nxt;
    logic [RRW-1:0]         w_req;
    logic [RRW-1:0]         w_child;
    logic                   w_req_ok;
    logic                   w_child_ok;
    logic                   w_grant;

    // Current busy (not the halt-updated value) drives child choice, so a core
    // freed this cycle becomes allocatable only on the next one.
    always_comb begin
        w_elig     = fork_req & r_busy & ~halt & ~r_ack;
        w_req      = '0;
        w_req_ok   = 1'b0;
        w_child    = '0;
        w_child_ok = 1'b0;
        for (int unsigned i = 0; i < NC_U; i++) begin
            w_start[i] = r_cxt[i*33 + 32];
        end
        for (int unsigned k = 0; k < NC_U; k++) begin
            if (!w_req_ok && w_elig[(32'(r_rr) + k) % NC_U]) begin
                w_req_ok = 1'b1;
                w_req    = RRW'((32'(r_rr) + k) % NC_U);
            end
        end
        for (int unsigned i = 0; i < NC_U; i++) begin
            if (!w_child_ok && !r_busy[i] && !w_start[i]) begin
                w_child_ok = 1'b1;
                w_child    = RRW'(i);
            end
        end
        w_grant    = (r_state == S_RUN) && w_req_ok && w_child_ok;
        w_busy_nxt = r_busy & ~halt;
        w_ack_nxt  = '0;
        w_cxt_nxt  = '0;
        if (w_grant) begin
            w_busy_nxt[w_child]              = 1'b1;
            w_ack_nxt[w_req]                 = 1'b1;
            w_cxt_nxt[int'(w_child)*33 +: 33] = {1'b1, fork_ptr[int'(w_req)*16 +: 16],
                                                 fork_pc[int'(w_req)*16 +: 16]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_BOOT;
            r_ack        <= '0;
            r_cxt        <= '0;
            r_busy       <= '0;
            r_done       <= 1'b0;
            r_rr         <= '0;
            r_fork_cnt   <= '0;
            r_starve_cnt <= '0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state <= S_RUN;
                    r_ack   <= '0;
                    r_cxt   <= {{((NCORES-1)*33){1'b0}}, 1'b1, BOOT_PTR, BOOT_PC};
                    r_busy  <= {{(NCORES-1){1'b0}}, 1'b1};
                    if (r_fork_cnt != 16'hFFFF) r_fork_cnt <= r_fork_cnt + 16'd1;
                end
                S_RUN: begin
                    if (r_busy == '0 && w_start == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_ack   <= '0;
                        r_cxt   <= '0;
                    end else begin
                        r_ack  <= w_ack_nxt;
                        r_cxt  <= w_cxt_nxt;
                        r_busy <= w_busy_nxt;
                        if (w_grant) begin
                            r_rr <= (w_req == RRW'(NCORES-1)) ? '0 : w_req + 1'b1;
                            if (r_fork_cnt != 16'hFFFF) r_fork_cnt <= r_fork_cnt + 16'd1;
                        end else if (w_elig != '0 && r_starve_cnt != 16'hFFFF) begin
                            r_starve_cnt <= r_starve_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    r_ack  <= '0;
                    r_cxt  <= '0;
                    r_busy <= '0;
                    r_done <= 1'b1;
                end
            endcase
        end
    end

    assign fork_ack = r_ack;
    assign fork_cxt = r_cxt;
    assign busy     = r_busy;
    assign all_done = r_done;
`ifdef FORK_SCHED_STATS_EN
    assign fork_count   = r_fork_cnt;
    assign starve_count = r_starve_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats = ^{r_fork_cnt, r_starve_cnt};
`endif

endmodule

// File: tb/tb_fork_sched.sv
// Self-checking bench for fork_sched: directed test-plan sequence, then random traffic
// checked every cycle against an array-based reference model.
module tb_fork_sched;

    localparam int          NC  = 4;
    localparam logic [15:0] BP  = 16'd128;
    localparam logic [15:0] BPC = 16'h0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NC-1:0]     fork_req = '0;
    logic [NC*16-1:0]  fork_ptr = '0;
    logic [NC*16-1:0]  fork_pc  = '0;
    logic [NC-1:0]     halt = '0;
    logic [NC-1:0]     fork_ack;
    logic [NC*33-1:0]  fork_cxt;
    logic [NC-1:0]     busy;
    logic              all_done;
`ifdef FORK_SCHED_STATS_EN
    logic [15:0]       fork_count;
    logic [15:0]       starve_count;
`endif

    fork_sched #(.NCORES(NC), .BOOT_PTR(BP), .BOOT_PC(BPC)) dut (
        .clk(clk), .rst(rst), .fork_req(fork_req), .fork_ptr(fork_ptr),
        .fork_pc(fork_pc), .halt(halt), .fork_ack(fork_ack), .fork_cxt(fork_cxt),
        .busy(busy), .all_done(all_done)
`ifdef FORK_SCHED_STATS_EN
        , .fork_count(fork_count), .starve_count(starve_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: phase 0 boot, 1 run, 2 done
    int          m_phase;
    bit          m_busy  [NC];
    bit          m_ack   [NC];
    logic [32:0] m_cxt   [NC];
    int          m_rr;
    bit          m_done;
    int          m_fc, m_sc;

    task automatic model_reset();
        m_phase = 0; m_rr = 0; m_done = 0; m_fc = 0; m_sc = 0;
        for (int i = 0; i < NC; i++) begin
            m_busy[i] = 0; m_ack[i] = 0; m_cxt[i] = '0;
        end
    endtask

    task automatic model_step();
        int  r, c, nbusy, nstart;
        bit  anyelig;
        bit  elig [NC];
        if (m_phase == 0) begin
            for (int i = 0; i < NC; i++) begin
                m_busy[i] = 0; m_ack[i] = 0; m_cxt[i] = '0;
            end
            m_cxt[0] = {1'b1, BP, BPC};
            m_busy[0] = 1;
            m_phase = 1;
            if (m_fc < 65535) m_fc++;
        end else if (m_phase == 1) begin
            nbusy = 0; nstart = 0; anyelig = 0;
            for (int i = 0; i < NC; i++) begin
                nbusy += int'(m_busy[i]);
                nstart += int'(m_cxt[i][32]);
                elig[i] = fork_req[i] && m_busy[i] && !halt[i] && !m_ack[i];
                anyelig |= elig[i];
            end
            if (nbusy == 0 && nstart == 0) begin
                m_phase = 2; m_done = 1;
                for (int i = 0; i < NC; i++) begin
                    m_ack[i] = 0; m_cxt[i] = '0;
                end
            end else begin
                r = -1; c = -1;
                for (int k = 0; k < NC; k++)
                    if (r < 0 && elig[(m_rr + k) % NC]) r = (m_rr + k) % NC;
                for (int i = 0; i < NC; i++)
                    if (c < 0 && !m_busy[i] && !m_cxt[i][32]) c = i;
                for (int i = 0; i < NC; i++) begin
                    if (halt[i]) m_busy[i] = 0;
                    m_ack[i] = 0; m_cxt[i] = '0;
                end
                if (r >= 0 && c >= 0) begin
                    m_ack[r]  = 1;
                    m_cxt[c]  = {1'b1, fork_ptr[r*16 +: 16], fork_pc[r*16 +: 16]};
                    m_busy[c] = 1;
                    m_rr      = (r + 1) % NC;
                    if (m_fc < 65535) m_fc++;
                end else if (anyelig) begin
                    if (m_sc < 65535) m_sc++;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [NC-1:0] eb, ea;
        for (int i = 0; i < NC; i++) begin
            eb[i] = m_busy[i]; ea[i] = m_ack[i];
            chk($sformatf("cxt%0d", i), 64'(fork_cxt[i*33 +: 33]), 64'(m_cxt[i]));
        end
        chk("ack", 64'(fork_ack), 64'(ea));
        chk("busy", 64'(busy), 64'(eb));
        chk("all_done", 64'(all_done), 64'(m_done));
`ifdef FORK_SCHED_STATS_EN
        chk("fork_count", 64'(fork_count), 64'(m_fc));
        chk("starve_count", 64'(starve_count), 64'(m_sc));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fork_req = '0; halt = '0;
        model_reset();
        #1;
        check_all();
        chk("rst_cxt_zero", 64'(fork_cxt == '0), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [15:0] p, input logic [15:0] pc);
        fork_req[i] = 1'b1;
        fork_ptr[i*16 +: 16] = p;
        fork_pc[i*16 +: 16]  = pc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Boot
        tick();
        chk("boot_cxt0", 64'(fork_cxt[32:0]), 64'({1'b1, 16'd128, 16'h0000}));
        chk("boot_busy", 64'(busy), 64'(4'b0001));
        tick();
        chk("boot_start_off", 64'(fork_cxt[32]), 64'd0);

        // Single fork
        set_req(0, 16'h0090, 16'h0010);
        tick();
        chk("fork_ack", 64'(fork_ack), 64'(4'b0001));
        chk("fork_cxt1", 64'(fork_cxt[33 +: 33]), 64'({1'b1, 16'h0090, 16'h0010}));
        chk("fork_busy", 64'(busy), 64'(4'b0011));
        fork_req = '0;
        tick();

        // Second fork leaves rr = 1, then cores 0 and 1 contend
        set_req(0, 16'h00A0, 16'h0020);
        tick();
        chk("fork2_cxt2", 64'(fork_cxt[66 +: 33]), 64'({1'b1, 16'h00A0, 16'h0020}));
        fork_req = '0;
        tick();
        set_req(0, 16'h00B0, 16'h0030);
        set_req(1, 16'h00C0, 16'h0040);
        tick();
        chk("rr_ack", 64'(fork_ack), 64'(4'b0010));
        chk("rr_cxt3", 64'(fork_cxt[99 +: 33]), 64'({1'b1, 16'h00C0, 16'h0040}));
        fork_req[1] = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("rr_wait_ack", 64'(fork_ack), 64'd0);
        end
        fork_req = '0;

        // Saturation, then halt frees core 3
        set_req(2, 16'h1234, 16'h5678);
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("sat_ack", 64'(fork_ack), 64'd0);
            chk("sat_busy", 64'(busy), 64'(4'b1111));
        end
        halt = 4'b1000;
        tick();
        chk("halt_busy", 64'(busy), 64'(4'b0111));
        chk("halt_noack", 64'(fork_ack), 64'd0);
        halt = '0;
        tick();
        chk("sat_grant_ack", 64'(fork_ack), 64'(4'b0100));
        chk("sat_grant_cxt3", 64'(fork_cxt[99 +: 33]), 64'({1'b1, 16'h1234, 16'h5678}));
        fork_req = '0;
        tick();

        // Halt and fork on the same core: halt wins
        set_req(1, 16'h7777, 16'h8888);
        halt = 4'b0010;
        tick();
        chk("halt_fork_ack", 64'(fork_ack), 64'd0);
        chk("halt_fork_busy", 64'(busy), 64'(4'b1101));
        fork_req = '0;

        // Done
        halt = 4'b1111;
        tick();
        chk("all_halted", 64'(busy), 64'd0);
        halt = '0;
        fork_req = 4'b1111;
        tick();
        chk("all_done", 64'(all_done), 64'd1);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("done_ignore", 64'({fork_ack, busy, all_done}), 64'({4'b0, 4'b0, 1'b1}));
        end
        fork_req = '0;

        // Reboot, then reset during a grant
        do_reset();
        tick();
        tick();
        set_req(0, 16'h4321, 16'h0042);
        tick();
        chk("pre_rst_ack", 64'(fork_ack), 64'(4'b0001));
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_async_ack", 64'(fork_ack), 64'd0);
        chk("rst_async_cxt", 64'(fork_cxt == '0), 64'd1);
        check_all();
        fork_req = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        chk("reboot_cxt0", 64'(fork_cxt[32:0]), 64'({1'b1, 16'd128, 16'h0000}));

        // Random traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int i = 0; i < NC; i++) begin
                if (m_ack[i] || halt[i]) fork_req[i] = 1'b0;
            end
            halt = '0;
            for (int i = 0; i < NC; i++) begin
                if (m_busy[i] && $urandom_range(15) == 0) halt[i] = 1'b1;
                else if (!m_busy[i] && $urandom_range(31) == 0) halt[i] = 1'b1;
                if (!fork_req[i] && $urandom_range(3) == 0)
                    set_req(i, 16'($urandom), 16'($urandom));
            end
            if (m_done || $urandom_range(499) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
